// File: rtl/brlite_local_port_pkg.sv
// Shared types for the BrLite local port bridge: flit payload layout, TX FSM states
// and the PE tag that is carried in the low byte of seq_source.
package brlite_local_port_pkg;

  localparam int unsigned BR_SEQ_W   = 8;
  localparam int unsigned BR_FIELD_W = 16;
  localparam int unsigned BR_KSVC_W  = 4;

  typedef struct packed {
    logic [BR_FIELD_W-1:0] seq_source;
    logic [BR_FIELD_W-1:0] payload;
    logic [BR_KSVC_W-1:0]  ksvc;
  } br_payload_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DONE = 2'd2
  } tx_state_e;

  // Compressed PE identity {x[3:0], y[3:0]} used for source stamping and echo detection
  function automatic logic [7:0] pe_tag(input logic [15:0] addr);
    return {addr[11:8], addr[3:0]};
  endfunction

endpackage

// File: rtl/brlite_rx_fifo.sv
// Synchronous RX FIFO of BrLite flits; pointer wrap at DEPTH (power of two, >= 2).
module brlite_rx_fifo
  import brlite_local_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  br_payload_t            data_i,
  output br_payload_t            head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  br_payload_t       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_c    = (r_count == CNT_W'(DEPTH));
  assign empty_c   = (r_count == '0);
  assign w_do_push = push_i && !full_c;
  assign w_do_pop  = pop_i && !empty_c;
  assign head_c    = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the occupancy unchanged
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/brlite_local_port.sv
// Bridge between the NI BrLite service ports and the router local port:
// RX echo filter + FIFO toward the NI, TX stamping FSM toward the router.
module brlite_local_port
  import brlite_local_port_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 4,
  parameter logic [15:0] ADDRESS     = 16'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        ni_rx_o,
  input  logic        ni_ack_i,
  output br_payload_t ni_data_o,
  input  logic        ni_req_i,
  output logic        ni_ack_o,
  input  br_payload_t ni_data_i,
  output logic        ni_busy_o,
  input  logic        rtr_req_i,
  output logic        rtr_ack_o,
  input  br_payload_t rtr_data_i,
  output logic        rtr_req_o,
  input  logic        rtr_ack_i,
  output br_payload_t rtr_data_o
);

  localparam int unsigned CNT_W  = $clog2(BUFFER_SIZE) + 1;
  localparam logic [7:0]  PE_TAG = pe_tag(ADDRESS);

  logic             w_echo;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             r_rtr_ack;
  logic             w_unused_seq;

  // RX: an echo is always accepted (and dropped); other flits need FIFO space
  assign w_echo   = (rtr_data_i.seq_source[7:0] == PE_TAG);
  assign w_accept = rtr_req_i && !r_rtr_ack && (w_echo || !w_full);
  assign w_push   = w_accept && !w_echo;
  assign w_pop    = ni_ack_i && !w_empty;

  brlite_rx_fifo #(
    .DEPTH(BUFFER_SIZE)
  ) u_rx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (w_push),
    .pop_i  (w_pop),
    .data_i (rtr_data_i),
    .head_c (ni_data_o),
    .full_c (w_full),
    .empty_c(w_empty),
    .count_o(w_count)
  );

  assign ni_rx_o   = (w_count != '0);
  assign rtr_ack_o = r_rtr_ack;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rtr_ack <= 1'b0;
    else         r_rtr_ack <= w_accept;
  end

  // TX: NI-provided seq_source is replaced by the local stamp
  assign w_unused_seq = ^ni_data_i.seq_source;

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic                 r_rtr_req;
  logic                 w_rtr_req_nxt;
  br_payload_t          r_rtr_data;
  br_payload_t          w_rtr_data_nxt;
  logic                 r_ni_ack;
  logic                 w_ni_ack_nxt;
  logic [BR_SEQ_W-1:0]  r_seq_cnt;
  logic [BR_SEQ_W-1:0]  w_seq_cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= TX_IDLE;
      r_rtr_req  <= 1'b0;
      r_rtr_data <= '0;
      r_ni_ack   <= 1'b0;
      r_seq_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rtr_req  <= w_rtr_req_nxt;
      r_rtr_data <= w_rtr_data_nxt;
      r_ni_ack   <= w_ni_ack_nxt;
      r_seq_cnt  <= w_seq_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rtr_req_nxt  = r_rtr_req;
    w_rtr_data_nxt = r_rtr_data;
    w_ni_ack_nxt   = 1'b0;
    w_seq_cnt_nxt  = r_seq_cnt;
    case (r_state)
      TX_IDLE: begin
        if (ni_req_i) begin
          w_rtr_data_nxt.seq_source = {r_seq_cnt, PE_TAG};
          w_rtr_data_nxt.payload    = ni_data_i.payload;
          w_rtr_data_nxt.ksvc       = ni_data_i.ksvc;
          w_rtr_req_nxt             = 1'b1;
          w_state_nxt               = TX_SEND;
        end
      end
      TX_SEND: begin
        if (rtr_ack_i) begin
          w_rtr_req_nxt = 1'b0;
          w_ni_ack_nxt  = 1'b1;
          w_seq_cnt_nxt = r_seq_cnt + BR_SEQ_W'(1);
          w_state_nxt   = TX_DONE;
        end
      end
      // One idle-gap cycle lets the NI drop its held request
      TX_DONE: w_state_nxt = TX_IDLE;
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign rtr_req_o  = r_rtr_req;
  assign rtr_data_o = r_rtr_data;
  assign ni_ack_o   = r_ni_ack;
  assign ni_busy_o  = (r_state != TX_IDLE);

endmodule

// File: tb/tb_brlite_local_port.sv
// Directed testbench for brlite_local_port (BUFFER_SIZE = 4, ADDRESS = 16'h0102).
module tb_brlite_local_port;
  import brlite_local_port_pkg::*;

  localparam logic [15:0] ADDR = 16'h0102;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ni_rx_o, ni_ack_i, ni_req_i, ni_ack_o, ni_busy_o;
  logic        rtr_req_i, rtr_ack_o, rtr_req_o, rtr_ack_i;
  br_payload_t ni_data_o, ni_data_i, rtr_data_i, rtr_data_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_seq = 0;

  always #5 clk = ~clk;

  brlite_local_port #(.BUFFER_SIZE(4), .ADDRESS(ADDR)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ni_rx_o(ni_rx_o), .ni_ack_i(ni_ack_i), .ni_data_o(ni_data_o),
    .ni_req_i(ni_req_i), .ni_ack_o(ni_ack_o), .ni_data_i(ni_data_i), .ni_busy_o(ni_busy_o),
    .rtr_req_i(rtr_req_i), .rtr_ack_o(rtr_ack_o), .rtr_data_i(rtr_data_i),
    .rtr_req_o(rtr_req_o), .rtr_ack_i(rtr_ack_i), .rtr_data_o(rtr_data_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Router side: present a flit, hold until acked (bounded); lat = cycles to ack or -1
  task automatic deliver(input br_payload_t f, output int lat);
    rtr_data_i = f; rtr_req_i = 1'b1; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rtr_ack_o) begin lat = i; break; end
    end
    rtr_req_i = 1'b0;
  endtask

  task automatic pop_once();
    ni_ack_i = 1'b1; tick(); ni_ack_i = 1'b0;
  endtask

  // NI side: one send with router ack after dly SEND cycles
  task automatic send(input logic [15:0] pl, input logic [3:0] ks, input int dly,
                      output br_payload_t sent, output logic hold_ok,
                      output int ack_pulses, output logic busy_after);
    ni_data_i = '{seq_source: 16'hFFFF, payload: pl, ksvc: ks};
    ni_req_i = 1'b1; hold_ok = 1'b1; ack_pulses = 0;
    tick();
    sent = rtr_data_o;
    if (!rtr_req_o || !ni_busy_o || ni_ack_o) hold_ok = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!rtr_req_o || !ni_busy_o || ni_ack_o || rtr_data_o !== sent) hold_ok = 1'b0;
    end
    rtr_ack_i = 1'b1; tick(); rtr_ack_i = 1'b0;
    if (ni_ack_o) ack_pulses++;
    if (!ni_busy_o || rtr_req_o) hold_ok = 1'b0;
    ni_req_i = 1'b0; tick();
    if (ni_ack_o) ack_pulses++;
    busy_after = ni_busy_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ni_ack_i = 0; ni_req_i = 0; ni_data_i = '0;
    rtr_req_i = 0; rtr_ack_i = 0; rtr_data_i = '0;
    repeat (3) tick();
    n_cmp++;
    if ({ni_rx_o, ni_ack_o, ni_busy_o, rtr_ack_o, rtr_req_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00000",
                        {ni_rx_o, ni_ack_o, ni_busy_o, rtr_ack_o, rtr_req_o});
    end
    n_cmp++;
    if ({ni_data_o, rtr_data_o} !== 72'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h expected 0", ni_data_o, rtr_data_o);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_rx_single();
    br_payload_t f;
    int lat;
    f = '{seq_source: 16'h0311, payload: 16'hBEEF, ksvc: 4'h5};
    deliver(f, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL rx_ack_lat: got %0d expected 1", lat); end
    n_cmp++;
    if (ni_rx_o !== 1'b1) begin n_err++; $display("FAIL rx_valid: got %b expected 1", ni_rx_o); end
    n_cmp++;
    if (ni_data_o !== f) begin n_err++; $display("FAIL rx_data: got %h expected %h", ni_data_o, f); end
    tick();
    n_cmp++;
    if (rtr_ack_o !== 1'b0) begin n_err++; $display("FAIL rx_ack_pulse: got %b expected 0", rtr_ack_o); end
    pop_once();
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL rx_pop: got %b expected 0", ni_rx_o); end
    pop_once();
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL rx_pop_empty: got %b expected 0", ni_rx_o); end
  endtask

  task automatic test_fifo_full();
    br_payload_t fl [5];
    int lat, bad_lat;
    logic early_ack;
    bad_lat = 0; early_ack = 1'b0;
    for (int i = 0; i < 5; i++)
      fl[i] = '{seq_source: 16'h0A00 + 16'(i), payload: 16'hC000 + 16'(i), ksvc: 4'(i)};
    // First flit starts from an idle cycle, the rest follow in the ack cycle
    for (int i = 0; i < 4; i++) begin
      deliver(fl[i], lat);
      if (lat !== ((i == 0) ? 1 : 2)) bad_lat++;
    end
    n_cmp++;
    if (bad_lat !== 0) begin n_err++; $display("FAIL fill_lat: got %0d bad expected 0", bad_lat); end
    rtr_data_i = fl[4]; rtr_req_i = 1'b1;
    repeat (4) begin tick(); if (rtr_ack_o) early_ack = 1'b1; end
    n_cmp++;
    if (early_ack !== 1'b0) begin n_err++; $display("FAIL full_block: got %b expected 0", early_ack); end
    n_cmp++;
    if (ni_data_o !== fl[0]) begin n_err++; $display("FAIL full_head: got %h expected %h", ni_data_o, fl[0]); end
    pop_once();
    n_cmp++;
    if (rtr_ack_o !== 1'b0) begin n_err++; $display("FAIL ack_in_pop_next: got %b expected 0", rtr_ack_o); end
    tick();
    n_cmp++;
    if (rtr_ack_o !== 1'b1) begin n_err++; $display("FAIL retry_ack: got %b expected 1", rtr_ack_o); end
    rtr_req_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (ni_data_o !== fl[i]) begin
        n_err++; $display("FAIL wrap_order_%0d: got %h expected %h", i, ni_data_o, fl[i]);
      end
      pop_once();
    end
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b expected 0", ni_rx_o); end
  endtask

  task automatic test_echo();
    br_payload_t e, fl;
    int lat;
    e = '{seq_source: 16'h3412, payload: 16'h5555, ksvc: 4'h9};
    deliver(e, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL echo_ack: got %0d expected 1", lat); end
    tick();
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL echo_dropped: got %b expected 0", ni_rx_o); end
    for (int i = 0; i < 4; i++) begin
      fl = '{seq_source: 16'h0B20 + 16'(i), payload: 16'hD000 + 16'(i), ksvc: 4'(i + 8)};
      deliver(fl, lat);
    end
    tick();
    deliver(e, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL echo_full_ack: got %0d expected 1", lat); end
    for (int i = 0; i < 4; i++) begin
      fl = '{seq_source: 16'h0B20 + 16'(i), payload: 16'hD000 + 16'(i), ksvc: 4'(i + 8)};
      n_cmp++;
      if (ni_data_o !== fl) begin
        n_err++; $display("FAIL echo_full_order_%0d: got %h expected %h", i, ni_data_o, fl);
      end
      pop_once();
    end
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL echo_not_stored: got %b expected 0", ni_rx_o); end
  endtask

  task automatic test_push_pop();
    br_payload_t a, b;
    int lat;
    a = '{seq_source: 16'h7701, payload: 16'h0A0A, ksvc: 4'h1};
    b = '{seq_source: 16'h7702, payload: 16'h0B0B, ksvc: 4'h2};
    deliver(a, lat);
    tick();
    rtr_data_i = b; rtr_req_i = 1'b1; ni_ack_i = 1'b1;
    tick();
    ni_ack_i = 1'b0;
    n_cmp++;
    if ({rtr_ack_o, ni_rx_o} !== 2'b11) begin
      n_err++; $display("FAIL pushpop_ctrl: got %b expected 11", {rtr_ack_o, ni_rx_o});
    end
    n_cmp++;
    if (ni_data_o !== b) begin n_err++; $display("FAIL pushpop_head: got %h expected %h", ni_data_o, b); end
    rtr_req_i = 1'b0;
    pop_once();
    n_cmp++;
    if (ni_rx_o !== 1'b0) begin n_err++; $display("FAIL pushpop_count: got %b expected 0", ni_rx_o); end
  endtask

  task automatic test_tx();
    br_payload_t s, s255, s256, exp;
    logic ok, ba;
    int ap;
    send(16'h1234, 4'h2, 3, s, ok, ap, ba);
    exp = '{seq_source: 16'h0012, payload: 16'h1234, ksvc: 4'h2};
    n_cmp++;
    if (s !== exp) begin n_err++; $display("FAIL tx_first: got %h expected %h", s, exp); end
    n_cmp++;
    if ({ok, ba} !== 2'b10) begin n_err++; $display("FAIL tx_hold_busy: got %b expected 10", {ok, ba}); end
    n_cmp++;
    if (ap !== 1) begin n_err++; $display("FAIL tx_ack_pulses: got %0d expected 1", ap); end
    send(16'h4321, 4'hC, 0, s, ok, ap, ba);
    exp = '{seq_source: 16'h0112, payload: 16'h4321, ksvc: 4'hC};
    n_cmp++;
    if (s !== exp) begin n_err++; $display("FAIL tx_second: got %h expected %h", s, exp); end
    s255 = '0; s256 = '0;
    for (int k = 2; k <= 256; k++) begin
      send(16'(k), 4'h3, 0, s, ok, ap, ba);
      if (k == 255) s255 = s;
      if (k == 256) s256 = s;
    end
    exp_seq = 257;
    n_cmp++;
    if (s255.seq_source !== 16'hFF12) begin
      n_err++; $display("FAIL tx_seq255: got %h expected ff12", s255.seq_source);
    end
    n_cmp++;
    if (s256.seq_source !== 16'h0012) begin
      n_err++; $display("FAIL tx_seq_wrap: got %h expected 0012", s256.seq_source);
    end
  endtask

  task automatic test_simultaneous();
    br_payload_t fx, s, exp;
    logic ok, ba;
    int ap, lat;
    fx  = '{seq_source: 16'h0533, payload: 16'hCAFE, ksvc: 4'hE};
    exp = '{seq_source: {8'(exp_seq), 8'h12}, payload: 16'hA5A5, ksvc: 4'h7};
    fork
      deliver(fx, lat);
      send(16'hA5A5, 4'h7, 2, s, ok, ap, ba);
    join
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL sim_rx_lat: got %0d expected 1", lat); end
    n_cmp++;
    if (s !== exp) begin n_err++; $display("FAIL sim_tx_data: got %h expected %h", s, exp); end
    n_cmp++;
    if ({ok, ap} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL sim_tx_hs: got %b/%0d expected 1/1", ok, ap); end
    n_cmp++;
    if (ni_data_o !== fx || ni_rx_o !== 1'b1) begin
      n_err++; $display("FAIL sim_rx_data: got %h expected %h", ni_data_o, fx);
    end
    pop_once();
  endtask

  task automatic test_reset_mid();
    br_payload_t fy, s, exp;
    logic ok, ba;
    int lat, ap;
    fy = '{seq_source: 16'h0644, payload: 16'h1111, ksvc: 4'h4};
    deliver(fy, lat);
    tick();
    ni_data_i = '{seq_source: 16'h0, payload: 16'h9999, ksvc: 4'h9}; ni_req_i = 1'b1;
    tick();
    n_cmp++;
    if ({rtr_req_o, ni_busy_o, ni_rx_o} !== 3'b111) begin
      n_err++; $display("FAIL rstmid_pre: got %b expected 111", {rtr_req_o, ni_busy_o, ni_rx_o});
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({rtr_req_o, ni_ack_o, ni_rx_o, ni_busy_o} !== 4'b0) begin
      n_err++; $display("FAIL rstmid_abort: got %b expected 0000", {rtr_req_o, ni_ack_o, ni_rx_o, ni_busy_o});
    end
    ni_req_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({ni_rx_o, ni_ack_o, rtr_req_o} !== 3'b0) begin
      n_err++; $display("FAIL rstmid_after: got %b expected 000", {ni_rx_o, ni_ack_o, rtr_req_o});
    end
    send(16'h2222, 4'h1, 0, s, ok, ap, ba);
    exp = '{seq_source: 16'h0012, payload: 16'h2222, ksvc: 4'h1};
    n_cmp++;
    if (s !== exp) begin n_err++; $display("FAIL rstmid_seq: got %h expected %h", s, exp); end
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_fifo_full();
    test_echo();
    test_push_pop();
    test_tx();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
